cpumc_arbiter: RTL and testbench

Sequencer and arbiter for the shared CPU memory bus (cpumc: 16-bit address, r_nw, 8-bit write data, OR-combined read data from cart PRG, WRAM and PPU registers). The bus has two masters: the RP2A03 core and the HCI debug host. The block stalls the core via RDY at a safe read cycle, grants the bus to HCI, and sequences HCI single-byte accesses with fixed latency and an ack. It replaces the combinational owner mux in the top level.

---
 rtl/cpumc_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cpumc_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpumc_arbiter.sv
// rtl/cpumc_arbiter.sv - cpumc bus arbiter: stalls the RP2A03 via RDY and sequences HCI single-byte accesses
// CPUMC_ARB_TIMEOUT_EN adds a bounded DRAIN and the drain_timeout_out sticky status.
module cpumc_arbiter #(
   parameter logic [15:0] IDLE_ADDR     = 16'h5000,
   parameter int          DRAIN_TIMEOUT = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [15:0] cpu_a_in,
   input  logic        cpu_r_nw_in,
   input  logic [7:0]  cpu_d_in,
   output logic        cpu_rdy_out,
   input  logic        hci_req_in,
   output logic        hci_gnt_out,
   input  logic        hci_stb_in,
   input  logic [15:0] hci_a_in,
   input  logic        hci_r_nw_in,
   input  logic [7:0]  hci_d_in,
   output logic        hci_ack_out,
   output logic [7:0]  hci_d_out,
   input  logic [7:0]  mem_d_in,
   output logic [15:0] mem_a_out,
   output logic        mem_r_nw_out,
   output logic [7:0]  mem_d_out
`ifdef CPUMC_ARB_TIMEOUT_EN
   ,
   output logic        drain_timeout_out
`endif
);

   localparam logic [2:0] S_CPU      = 3'd0;
   localparam logic [2:0] S_DRAIN    = 3'd1;
   localparam logic [2:0] S_HCI_IDLE = 3'd2;
   localparam logic [2:0] S_HCI_ADDR = 3'd3;
   localparam logic [2:0] S_HCI_DATA = 3'd4;
   localparam logic [2:0] S_RELEASE  = 3'd5;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [2:0]  cur;
   logic [15:0] lat_a;
   logic        lat_r_nw;
   logic [7:0]  lat_d;
   logic        drain_expired;

`ifdef CPUMC_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);

   logic [CNT_W-1:0] drain_cnt;
   logic             timeout_flag;

   assign drain_expired     = (drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1));
   assign drain_timeout_out = timeout_flag;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drain_cnt    <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (state == S_DRAIN)
            drain_cnt <= drain_cnt + 1'b1;
         else
            drain_cnt <= '0;
         // Set only when the grant is forced, i.e. the core never offered a read.
         if (state == S_DRAIN && hci_req_in && !cpu_r_nw_in && drain_expired)
            timeout_flag <= 1'b1;
         else if (state == S_RELEASE)
            timeout_flag <= 1'b0;
      end
   end
`else
   logic unused_drain_timeout;
   assign unused_drain_timeout = |DRAIN_TIMEOUT;
   assign drain_expired        = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_CPU:      if (hci_req_in) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (!hci_req_in)
               state_nxt = S_CPU;
            else if (cpu_r_nw_in || drain_expired)
               state_nxt = S_HCI_IDLE;
         end
         S_HCI_IDLE: begin
            if (hci_stb_in)
               state_nxt = S_HCI_ADDR;
            else if (!hci_req_in)
               state_nxt = S_RELEASE;
         end
         S_HCI_ADDR: state_nxt = S_HCI_DATA;
         S_HCI_DATA: state_nxt = S_HCI_IDLE;
         S_RELEASE:  state_nxt = S_CPU;
         default:    state_nxt = S_CPU;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= S_CPU;
         lat_a       <= 16'h0000;
         lat_r_nw    <= 1'b1;
         lat_d       <= 8'h00;
         hci_ack_out <= 1'b0;
         hci_d_out   <= 8'h00;
      end else begin
         state       <= state_nxt;
         hci_ack_out <= (state == S_HCI_DATA);
         if (state == S_HCI_IDLE && hci_stb_in) begin
            lat_a    <= hci_a_in;
            lat_r_nw <= hci_r_nw_in;
            lat_d    <= hci_d_in;
         end
         if (state == S_HCI_DATA && lat_r_nw)
            hci_d_out <= mem_d_in;
      end
   end

   // Reset forces the CPU view immediately so an HCI write in flight never reaches memory.
   assign cur = rst_in ? S_CPU : state;

   always_comb begin
      cpu_rdy_out  = 1'b0;
      hci_gnt_out  = 1'b0;
      mem_a_out    = cpu_a_in;
      mem_r_nw_out = cpu_r_nw_in;
      mem_d_out    = cpu_d_in;
      case (cur)
         S_CPU:   cpu_rdy_out = 1'b1;
         S_DRAIN: cpu_rdy_out = 1'b0;
         S_HCI_IDLE: begin
            hci_gnt_out  = 1'b1;
            mem_a_out    = IDLE_ADDR;
            mem_r_nw_out = 1'b1;
            mem_d_out    = 8'h00;
         end
         S_HCI_ADDR: begin
            hci_gnt_out  = 1'b1;
            mem_a_out    = lat_a;
            mem_r_nw_out = lat_r_nw;
            mem_d_out    = lat_d;
         end
         S_HCI_DATA: begin
            hci_gnt_out  = 1'b1;
            mem_a_out    = lat_a;
            mem_r_nw_out = 1'b1;
            mem_d_out    = lat_d;
         end
         S_RELEASE: begin
            mem_a_out    = IDLE_ADDR;
            mem_r_nw_out = 1'b1;
            mem_d_out    = 8'h00;
         end
         default: cpu_rdy_out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_cpumc_arbiter.sv
// tb/tb_cpumc_arbiter.sv - cycle-vector and scoreboard bench for cpumc_arbiter
module tb_cpumc_arbiter;

   logic        clk = 1'b0;
   logic        rst, req, stb, h_rnw, c_rnw, rdy, gnt, ack, m_rnw;
   logic [15:0] h_a, c_a, m_a;
   logic [7:0]  h_d, c_d, hd_out, m_d_in, m_d;
`ifdef CPUMC_ARB_TIMEOUT_EN
   logic        status;
`endif

   always #5 clk = ~clk;

   cpumc_arbiter #(.IDLE_ADDR(16'h5000), .DRAIN_TIMEOUT(16)) dut (
      .clk_in(clk), .rst_in(rst),
      .cpu_a_in(c_a), .cpu_r_nw_in(c_rnw), .cpu_d_in(c_d), .cpu_rdy_out(rdy),
      .hci_req_in(req), .hci_gnt_out(gnt), .hci_stb_in(stb), .hci_a_in(h_a),
      .hci_r_nw_in(h_rnw), .hci_d_in(h_d), .hci_ack_out(ack), .hci_d_out(hd_out),
      .mem_d_in(m_d_in), .mem_a_out(m_a), .mem_r_nw_out(m_rnw), .mem_d_out(m_d)
`ifdef CPUMC_ARB_TIMEOUT_EN
      , .drain_timeout_out(status)
`endif
   );

   // 2 KB WRAM at 0000-07FF, synchronous read; everything else reads 00.
   logic [7:0] wram [0:2047];
   bit         loaded;
   always @(posedge clk) begin
      m_d_in <= (m_rnw && m_a < 16'h0800) ? wram[m_a[10:0]] : 8'h00;
      if (!m_rnw && m_a < 16'h0800) wram[m_a[10:0]] = m_d;
      if (rst && !loaded) begin
         wram[11'h123] = 8'hA5;
         wram[11'h204] = 8'h5A;
         loaded = 1'b1;
      end
   end

   typedef struct packed {
      logic rst, req, stb;
      logic [15:0] ha;
      logic hrnw;
      logic [7:0] hd;
      logic [15:0] ca;
      logic crnw;
   } in_t;
   typedef struct packed {
      logic rdy, gnt, ack;
      logic [15:0] ma;
      logic mrnw;
      logic [7:0] md, hdo;
   } out_t;
   typedef struct packed { in_t i; out_t o; } vec_t;

   vec_t vecs[$];
   out_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic add(input logic r, q, s, input logic [15:0] ha, input logic hrnw, input logic [7:0] hd,
                      input logic [15:0] ca, input logic crnw,
                      input logic e_rdy, e_gnt, e_ack, input logic [15:0] e_ma, input logic e_rnw,
                      input logic [7:0] e_md, e_hdo);
      vec_t v;
      v.i = '{r, q, s, ha, hrnw, hd, ca, crnw};
      v.o = '{e_rdy, e_gnt, e_ack, e_ma, e_rnw, e_md, e_hdo};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   initial begin
      out_t e, a;
      int   cnt;
      rst = 1; req = 1; stb = 0; h_a = 0; h_rnw = 1; h_d = 0; c_a = 16'h8000; c_rnw = 1; c_d = 8'hE7;

      //   rst req stb h_a       hrnw h_d    c_a       crnw | rdy gnt ack m_a       rnw m_d    hd_out
      add(1, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h0300, 0,   1, 0, 0, 16'h0300, 0, 8'hE7, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h0301, 0,   0, 0, 0, 16'h0301, 0, 8'hE7, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h0302, 0,   0, 0, 0, 16'h0302, 0, 8'hE7, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h0303, 0,   0, 0, 0, 16'h0303, 0, 8'hE7, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8004, 1,   0, 0, 0, 16'h8004, 1, 8'hE7, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h5000, 1, 8'h00, 8'h00);
      add(0, 1, 1, 16'h0123, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h5000, 1, 8'h00, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0123, 1, 8'h00, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0123, 1, 8'h00, 8'h00);
      add(0, 1, 1, 16'h0200, 0, 8'h3C, 16'h8000, 1,   0, 1, 1, 16'h5000, 1, 8'h00, 8'hA5);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0200, 0, 8'h3C, 8'hA5);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0200, 1, 8'h3C, 8'hA5);
      add(0, 1, 1, 16'h0200, 1, 8'h00, 16'h8000, 1,   0, 1, 1, 16'h5000, 1, 8'h00, 8'hA5);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0200, 1, 8'h00, 8'hA5);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0200, 1, 8'h00, 8'hA5);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 1, 16'h5000, 1, 8'h00, 8'h3C);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 0, 0, 16'h5000, 1, 8'h00, 8'h3C);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'h3C);
      // request withdrawn during DRAIN
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h0310, 0,   1, 0, 0, 16'h0310, 0, 8'hE7, 8'h3C);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h0310, 0,   0, 0, 0, 16'h0310, 0, 8'hE7, 8'h3C);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'h3C);
      // minimum grant latency, request withdrawn during ADDR
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'h3C);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 0, 0, 16'h8000, 1, 8'hE7, 8'h3C);
      add(0, 1, 1, 16'h0123, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h5000, 1, 8'h00, 8'h3C);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0123, 1, 8'h00, 8'h3C);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0123, 1, 8'h00, 8'h3C);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 1, 16'h5000, 1, 8'h00, 8'hA5);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 0, 0, 16'h5000, 1, 8'h00, 8'hA5);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'hA5);
      // reset lands on an HCI write in ADDR; the write must not reach WRAM
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'hA5);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 0, 0, 16'h8000, 1, 8'hE7, 8'hA5);
      add(0, 1, 1, 16'h0204, 0, 8'h77, 16'h8000, 1,   0, 1, 0, 16'h5000, 1, 8'h00, 8'hA5);
      add(1, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'hA5);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 0, 0, 16'h8000, 1, 8'hE7, 8'h00);
      add(0, 1, 1, 16'h0204, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h5000, 1, 8'h00, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0204, 1, 8'h00, 8'h00);
      add(0, 1, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 0, 16'h0204, 1, 8'h00, 8'h00);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 1, 1, 16'h5000, 1, 8'h00, 8'h5A);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   0, 0, 0, 16'h5000, 1, 8'h00, 8'h5A);
      add(0, 0, 0, 16'h0000, 1, 8'h00, 16'h8000, 1,   1, 0, 0, 16'h8000, 1, 8'hE7, 8'h5A);

      @(posedge clk);
      foreach (vecs[n]) begin
         @(posedge clk);
         #1;
         {rst, req, stb, h_a, h_rnw, h_d, c_a, c_rnw} = vecs[n].i;
         exp_q.push_back(vecs[n].o);
         @(negedge clk);
         e = exp_q.pop_front();
         a = '{rdy, gnt, ack, m_a, m_rnw, m_d, hd_out};
         n_vec++;
         if (a !== e) begin
            n_miss++;
            $display("FAIL row %0d: got rdy=%b gnt=%b ack=%b a=%h rnw=%b d=%h hd=%h want rdy=%b gnt=%b ack=%b a=%h rnw=%b d=%h hd=%h",
                     n, a.rdy, a.gnt, a.ack, a.ma, a.mrnw, a.md, a.hdo, e.rdy, e.gnt, e.ack, e.ma, e.mrnw, e.md, e.hdo);
         end
      end

      // core stuck issuing writes while HCI requests
      @(posedge clk);
      #1;
      rst = 0; req = 1; stb = 0; c_a = 16'h0310; c_rnw = 0;
      @(negedge clk);
      check("wloop_cpu_rdy", rdy, 1);
`ifdef CPUMC_ARB_TIMEOUT_EN
      cnt = 0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (gnt !== 1'b0 || rdy !== 1'b0) cnt++;
      end
      check("timeout_early_gnt", cnt, 0);
      @(posedge clk);
      #1 req = 0;
      @(negedge clk);
      check("timeout_gnt", gnt, 1);
      check("timeout_status", status, 1);
      @(posedge clk);
      @(negedge clk);
      check("timeout_release_gnt", gnt, 0);
      check("timeout_release_rdy", rdy, 0);
      @(posedge clk);
      @(negedge clk);
      check("timeout_status_clr", status, 0);
      check("timeout_rdy", rdy, 1);
`else
      cnt = 0;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (gnt !== 1'b0 || rdy !== 1'b0) cnt++;
      end
      check("no_timeout_gnt", cnt, 0);
      @(posedge clk);
      #1 req = 0;
      @(negedge clk);
      check("no_timeout_drain_rdy", rdy, 0);
      @(posedge clk);
      @(negedge clk);
      check("no_timeout_rdy", rdy, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
